dmem_responder: RTL
===================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH, default 32, SHALL set the number of 32-bit words stored; power of two, 4..1024.
REQ-002 Parameter LATENCY, default 3, SHALL set request-accept-to-completion cycles; legal range 1..15.
REQ-003 clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 rst_i  input  1  reset; synchronous, active-high.
REQ-005 MemRead_i  input  1  load request from the pipeline's MEM stage.
REQ-006 MemWrite_i  input  1  store request from the pipeline's MEM stage.
REQ-007 Addr_i  input  32  byte address; the word index is Addr_i[log2(DEPTH)+1:2].
REQ-008 WriteData_i  input  32  store data.
REQ-009 ReadData_o  output  32  load result, registered.
REQ-010 stall_o  output  1  freezes PC and all pipeline registers while high.
REQ-011 ack_o  output  1  one-cycle completion pulse.
REQ-012 err_o  output  1  misaligned-access flag; active only under REQ-029.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, WAIT, DONE.
REQ-014 In IDLE, (MemRead_i | MemWrite_i) SHALL start a request and capture the address, write data and op into internal registers.
- Next state: WAIT with counter = LATENCY-1.
- If LATENCY==1, next state is DONE directly.
REQ-015 In WAIT, the counter SHALL decrement each cycle; at count 1 the next state is DONE.
REQ-016 In DONE, the block SHALL commit the captured request, pulse ack_o=1 for that one cycle, and return to IDLE.
- Store: write the word into the array.
- Load: register the word into ReadData_o.
REQ-017 stall_o SHALL equal (IDLE & request) | WAIT, combinationally.
- stall_o is high for exactly LATENCY cycles per request, starting in the accept cycle.
- stall_o is low in DONE, so the pipeline advances on the DONE edge.
REQ-018 Inputs SHALL be sampled only in the IDLE accept cycle; changes during WAIT/DONE SHALL be ignored.
REQ-019 MemRead_i and MemWrite_i both high SHALL be treated as a store, and ReadData_o SHALL then be loaded with WriteData_i.
REQ-020 ReadData_o SHALL hold its value until the next completed load (or REQ-019 store).
- A plain store SHALL NOT alter ReadData_o.
REQ-021 An address beyond DEPTH SHALL wrap modulo DEPTH (upper bits ignored); no error is raised.
REQ-022 A request present in the IDLE cycle immediately after DONE SHALL be accepted with no bubble, giving back-to-back operation.
REQ-023 ack_o SHALL never be high in IDLE or WAIT.
REQ-024 The array SHALL NOT be reset, and SHALL be initialisable by testbench hierarchical access.

Reset
REQ-025 rst_i=1 at a clock edge SHALL set state=IDLE, counter=0, ReadData_o=0, ack_o=0, err_o=0.
REQ-026 Reset during WAIT or DONE SHALL abort the request; a pending store SHALL NOT be committed.
REQ-027 While rst_i=1, stall_o SHALL be 0 regardless of the request inputs.
REQ-028 Array contents SHALL be unaffected by reset.

Configuration
REQ-029 With DMEM_ALIGN_CHECK_EN defined, a request with Addr_i[1:0]!=0 SHALL complete normally in timing, with the following differences in DONE:
- err_o=1 together with ack_o.
- Store suppressed.
- ReadData_o set to 32'hDEADBEEF.
REQ-030 Without DMEM_ALIGN_CHECK_EN, err_o SHALL be tied 0, and Addr_i[1:0] SHALL be ignored.

Verification
REQ-031 Reset, then store 32'h0000_00A5 to 0x10, LATENCY=3 -> stall_o high cycles 0-2, ack_o at cycle 3, word 4 = 0xA5, ReadData_o unchanged (0).
REQ-032 Load 0x10 after REQ-031 -> ack_o at cycle 3, ReadData_o=0xA5 from cycle 4, stall_o low from cycle 3.
REQ-033 LATENCY=1, back-to-back store 0x5 to 0x0 then load 0x0 -> two ack_o pulses 2 cycles apart, ReadData_o=0x5, no idle cycle between requests.
REQ-034 Store 0xFFFF_FFFF to 0x8, rst_i asserted in WAIT cycle 1 -> no ack_o, word 2 keeps its prior value, ReadData_o=0, stall_o=0.
REQ-035 Load 0x84 with DEPTH=32 -> returns word 1 (wrap-around); change Addr_i during WAIT -> result unaffected.
REQ-036 DMEM_ALIGN_CHECK_EN defined, store 0x1234 to 0x6 -> err_o=ack_o=1 in DONE, word 1 unchanged, ReadData_o=0xDEADBEEF; macro undefined -> word 1 = 0x1234, err_o=0.

Source files
------------

// File: rtl/dmem_responder.sv
// Fixed-latency data memory responder for a stalling in-order pipeline: IDLE/WAIT/DONE handshake.
// Optional DMEM_ALIGN_CHECK_EN flags misaligned accesses (err_o, store suppressed, 0xDEADBEEF read).
module dmem_responder #(
  parameter int DEPTH   = 32,
  parameter int LATENCY = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] Addr_i,
  input  logic [31:0] WriteData_i,
  output logic [31:0] ReadData_o,
  output logic        stall_o,
  output logic        ack_o,
  output logic        err_o
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t        r_state, w_next;
  logic [3:0]    r_cnt, w_cnt;
  logic [AW-1:0] r_idx;
  logic [31:0]   r_wdata;
  logic          r_wr, r_rd, r_mis;
  logic [31:0]   r_mem [DEPTH];

  logic w_req, w_accept, w_mis, w_unused;

  assign w_req    = MemRead_i | MemWrite_i;
  assign w_accept = (r_state == S_IDLE) & w_req;
  assign stall_o  = ~rst_i & (w_accept | (r_state == S_WAIT));
  assign ack_o    = (r_state == S_DONE);
  assign w_unused = ^{Addr_i[31:AW+2], Addr_i[1:0]};

`ifdef DMEM_ALIGN_CHECK_EN
  assign w_mis = |Addr_i[1:0];
  assign err_o = (r_state == S_DONE) & r_mis;
`else
  assign w_mis = 1'b0;
  assign err_o = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    w_cnt  = r_cnt;
    unique case (r_state)
      S_IDLE: if (w_req) begin
        if (LATENCY == 1) w_next = S_DONE;
        else begin
          w_next = S_WAIT;
          w_cnt  = 4'(LATENCY - 1);
        end
      end
      S_WAIT: begin
        if (r_cnt <= 4'd1) begin
          w_next = S_DONE;
          w_cnt  = 4'd0;
        end else w_cnt = r_cnt - 4'd1;
      end
      S_DONE: begin
        w_next = S_IDLE;
        w_cnt  = 4'd0;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt;
    end
  end

  // Request is latched once at accept; later input changes cannot affect it.
  always_ff @(posedge clk_i) begin
    if (w_accept) begin
      r_idx   <= Addr_i[AW+1:2];
      r_wdata <= WriteData_i;
      r_wr    <= MemWrite_i;
      r_rd    <= MemRead_i;
      r_mis   <= w_mis;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && r_state == S_DONE && r_wr && !r_mis) r_mem[r_idx] <= r_wdata;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) ReadData_o <= '0;
    else if (r_state == S_DONE) begin
      if (r_mis)             ReadData_o <= 32'hDEADBEEF;
      else if (r_wr && r_rd) ReadData_o <= r_wdata;
      else if (r_rd)         ReadData_o <= r_mem[r_idx];
    end
  end
endmodule
